// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use, branch/jump flushes, multi-cycle
// jump-with-forwarding stall, data-memory wait hold and a stall statistics counter.
module pipe_hazard_ctrl #(
  parameter int JR_STALL = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic [1:0]       jump,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             stat_clr,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             back_hold,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, MEMWAIT, JRWAIT} state_e;

  localparam logic [3:0] JR_LOAD = 4'(JR_STALL - 1);

  state_e           state_q, state_d;
  logic [3:0]       jr_cnt_q, jr_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             mem_stall, load_use, mem_hold;

  assign mem_stall = dmem_req & ~dmem_ready;
  assign load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                     ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  always_comb begin
    state_d    = state_q;
    jr_cnt_d   = jr_cnt_q;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    back_hold  = 1'b0;
    mem_hold   = 1'b0;
    case (state_q)
      JRWAIT: begin
        if (mem_stall) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          back_hold  = 1'b1;
        end else if (branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          state_d    = RUN;
        end else if (jr_cnt_q != 4'd0) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          jr_cnt_d   = jr_cnt_q - 4'd1;
        end else begin
          ifid_flush = 1'b1;
          state_d    = RUN;
        end
      end
      default: begin
        // Once waiting, only dmem_ready ends the hold; the release cycle then
        // acts as RUN so a branch held in EX still gets its flush.
        mem_hold = (state_q == MEMWAIT) ? ~dmem_ready : mem_stall;
        if (mem_hold) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          back_hold  = 1'b1;
          state_d    = MEMWAIT;
        end else begin
          state_d = RUN;
          if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
          end else if (jump == 2'b10) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            jr_cnt_d   = JR_LOAD;
            state_d    = JRWAIT;
          end else if (jump == 2'b01) begin
            ifid_flush = 1'b1;
          end
        end
      end
    endcase
    if (!rst_n) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      back_hold  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      jr_cnt_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      jr_cnt_q <= jr_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stat_clr) begin
      stall_cnt_q <= '0;
    end else if (!pc_write && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and random checks of pipe_hazard_ctrl against a cycle-level
// behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;
  localparam int JR  = 2;
  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    id_rs, id_rt, ex_rd;
  logic          id_uses_rt, ex_mem_read, branch_taken, dmem_req, dmem_ready, stat_clr;
  logic [1:0]    jump;
  logic          pc_write, ifid_write, ifid_flush, idex_flush, back_hold;
  logic [CW-1:0] stall_cnt;

  int total = 0;
  int bad = 0;

  // model: waiting on memory, inside a jump-with-forwarding stall, stalls left
  bit m_mem, m_jr;
  int m_left, m_cnt;
  bit n_mem, n_jr;
  int n_left;
  logic [4:0] e_out;  // {pc_write, ifid_write, ifid_flush, idex_flush, back_hold}

  pipe_hazard_ctrl #(.JR_STALL(JR), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .jump(jump), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .stat_clr(stat_clr),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .back_hold(back_hold), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_comb();
    bit mem, lu, hold;
    mem = dmem_req && !dmem_ready;
    lu  = ex_mem_read && ex_rd != 0 && (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
    n_mem = m_mem; n_jr = m_jr; n_left = m_left;
    e_out = 5'b11000;
    if (!rst_n) begin
      e_out = 5'b00110; n_mem = 0; n_jr = 0; n_left = 0;
    end else if (m_jr) begin
      if (mem) e_out = 5'b00011;
      else if (branch_taken) begin e_out = 5'b11110; n_jr = 0; end
      else if (m_left > 0) begin e_out = 5'b00010; n_left = m_left - 1; end
      else begin e_out = 5'b11100; n_jr = 0; end
    end else begin
      hold = m_mem ? !dmem_ready : mem;
      n_mem = hold;
      if (hold) e_out = 5'b00001;
      else if (branch_taken) e_out = 5'b11110;
      else if (lu) e_out = 5'b00010;
      else if (jump == 2'b10) begin e_out = 5'b00010; n_jr = 1; n_left = JR - 1; end
      else if (jump == 2'b01) e_out = 5'b11100;
    end
  endtask

  task automatic model_commit();
    if (!rst_n) begin
      m_mem = 0; m_jr = 0; m_left = 0; m_cnt = 0;
    end else begin
      m_mem = n_mem; m_jr = n_jr; m_left = n_left;
      if (stat_clr) m_cnt = 0;
      else if (!e_out[4] && m_cnt < MAX) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic step(input string tag);
    #2;
    model_comb();
    chk({tag, ".outs"}, {pc_write, ifid_write, ifid_flush, idex_flush, back_hold}, e_out);
    @(posedge clk);
    model_commit();
    #1;
    chk({tag, ".cnt"}, stall_cnt, m_cnt);
  endtask

  task automatic idle();
    id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
    jump = 2'b00; branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0; stat_clr = 1'b0;
  endtask

  initial begin
    m_mem = 0; m_jr = 0; m_left = 0; m_cnt = 0;
    idle();
    #1;
    chk("rst.outs", {pc_write, ifid_write, ifid_flush, idex_flush, back_hold}, 5'b00110);
    chk("rst.cnt", stall_cnt, 0);
    step("rst_a");
    step("rst_b");
    rst_n = 1'b1;
    step("run_default");

    // load-use on rs
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
    step("lu");
    idle();
    step("lu_after");
    chk("lu_cnt", stall_cnt, 1);

    // load-use on rt only when rt is read
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1;
    step("lu_rt");
    id_uses_rt = 1'b0;
    step("lu_rt_unused");

    // r0 load never stalls
    idle(); stat_clr = 1'b1;
    step("clr");
    stat_clr = 1'b0; ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
    step("lu_r0");
    chk("lu_r0_cnt", stall_cnt, 0);

    // jump with forwarding held: two stalls then release
    idle(); jump = 2'b10;
    step("jr_s1");
    step("jr_s2");
    step("jr_rel");
    chk("jr_cnt", stall_cnt, 2);
    jump = 2'b00;
    step("jr_after");
    jump = 2'b01;
    step("jmp01");
    idle();

    // memory wait with pending branch
    dmem_req = 1'b1; branch_taken = 1'b1;
    step("mw1");
    step("mw2");
    step("mw3");
    dmem_ready = 1'b1;
    step("mw_rel_branch");
    idle();
    step("mw_after");

    // jump stall interrupted by memory wait, then branch abort
    jump = 2'b10;
    step("jrm_s1");
    jump = 2'b00; dmem_req = 1'b1;
    step("jrm_hold1");
    step("jrm_hold2");
    dmem_req = 1'b0; branch_taken = 1'b1;
    step("jrm_abort");
    idle();
    step("jrm_after");

    // saturation and clear priority
    stat_clr = 1'b1;
    step("sat_clr0");
    stat_clr = 1'b0; ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs = 5'd3;
    for (int i = 0; i < MAX + 4; i++) step("sat_fill");
    chk("sat_max", stall_cnt, MAX);
    stat_clr = 1'b1;
    step("sat_clr_stall");
    chk("sat_cleared", stall_cnt, 0);
    idle();

    // reset mid JRWAIT
    ex_mem_read = 1'b1; ex_rd = 5'd4; id_rs = 5'd4;
    step("pre_rst_lu");
    idle(); jump = 2'b10;
    step("rjr_s1");
    jump = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    chk("rjr.outs", {pc_write, ifid_write, ifid_flush, idex_flush, back_hold}, 5'b00110);
    chk("rjr.cnt", stall_cnt, 0);
    m_mem = 0; m_jr = 0; m_left = 0; m_cnt = 0;
    step("rjr_held");
    rst_n = 1'b1;
    step("rjr_run");
    chk("rjr_run_cnt", stall_cnt, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      ex_rd        = 5'($urandom_range(0, 3));
      id_uses_rt   = 1'($urandom_range(0, 1));
      ex_mem_read  = ($urandom_range(0, 2) == 0);
      jump         = 2'($urandom_range(0, 3));
      branch_taken = ($urandom_range(0, 7) == 0);
      dmem_req     = ($urandom_range(0, 3) == 0);
      dmem_ready   = 1'($urandom_range(0, 1));
      stat_clr     = ($urandom_range(0, 31) == 0);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
